non_restoring_divider_param: RTL
================================

Name: non_restoring_divider_param

Overview:
- Self-contained, parametrised iterative non-restoring divider: datapath plus controller FSM in one block.
- Generalises the fixed 16-bit datapath to WIDTH bits.
- Adds a start/busy/done handshake, optional signed mode, and divide-by-zero and signed-overflow detection.
- Sits behind the arithmetic issue logic; one division in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- dividend  input  WIDTH  dividend; sampled with start
- divisor  input  WIDTH  divisor; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered flag, valid with done
- overflow  output  1  registered flag, valid with done (signed MIN / -1)

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - busy, done, div_by_zero and overflow = 0.
  - quotient and remainder = 0.
  - Counter, A and Q registers cleared.
  - Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, ITER, FIXUP, DONE.
- IDLE, start=1 (edge t0): operands, signed_mode and operand signs are captured.
  - divisor==0: go to DONE.
    - quotient = all ones, remainder = dividend unchanged, div_by_zero=1, overflow=0.
  - Signed, dividend = 100..0, divisor = all ones: go to DONE.
    - quotient = 100..0, remainder = 0, overflow=1.
  - Otherwise: load Q = |dividend|, M = |divisor| (magnitudes only when signed_mode=1), A = 0 (WIDTH+1 bits, MSB is sign). Go to ITER, counter = 0.
- ITER, one iteration per cycle:
  - {A,Q} shifted left by 1.
  - If A was negative before the shift, A = A + M; else A = A - M.
  - Q[0] = ~A_new[WIDTH].
  - After WIDTH iterations (counter == WIDTH-1), go to FIXUP.
- FIXUP:
  - If A is negative, A = A + M.
  - Signed mode: quotient negated if the operand signs differ; remainder negated if the dividend was negative (truncation toward zero, remainder takes the dividend's sign).
  - Results are loaded into the output registers and the state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then back to IDLE.
- Latency:
  - Normal path: done high in cycle t0+WIDTH+2.
  - Zero or overflow path: done high in cycle t0+1.
- busy:
  - 1 in ITER and FIXUP.
  - 0 in IDLE and DONE.
- start while busy or in DONE is ignored and not queued.
- Operand inputs may change freely after t0.
- Outputs and flags hold their last values until the next accepted start loads new results.
- Flags are cleared when a normal-path result loads.
- Unsigned mode: no sign handling; the full WIDTH-bit magnitude range is valid.

Test Plan:
- Unsigned, WIDTH=16, 100 / 7 -> quotient=14, remainder=2, done exactly 18 cycles after start is sampled, busy high for 17 cycles.
- Signed -100 (0xFF9C) / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2); signed 100 / -7 -> quotient=0xFFF2, remainder=0x0002.
- Unsigned 0xFFFF / 0x0001 -> quotient=0xFFFF, remainder=0; unsigned 0x1234 / 0 -> div_by_zero=1, quotient=0xFFFF, remainder=0x1234, done 1 cycle after start.
- Signed 0x8000 / 0xFFFF -> overflow=1, quotient=0x8000, remainder=0, done after 1 cycle; the same operands unsigned -> quotient=0, remainder=0x8000, overflow=0.
- start re-asserted at cycle 5 of a division -> ignored, first result unchanged; a new start one cycle after done is accepted.
- rst pulsed low in ITER cycle 8 -> busy and done drop immediately, outputs=0, no done pulse; the next division completes correctly.

Source files
------------

// File: rtl/non_restoring_divider_param.sv
// Iterative non-restoring divider, WIDTH-bit operands, unsigned or two's-complement.
// Latency: WIDTH+2 cycles from start to done; divide-by-zero and MIN/-1 finish in 1.
// Backpressure: single division in flight; start is ignored while busy or done.
module non_restoring_divider_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic               neg_q;
    logic               neg_r;

    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     a_sh;
    logic [WIDTH:0]     a_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   a_fix;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;

    always_comb begin
        dvd_neg = signed_mode & dividend[WIDTH-1];
        dvs_neg = signed_mode & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor  : divisor;

        // Add/subtract choice uses the sign of A before the shift; the shifted
        // value may wrap in WIDTH+1 bits but the post-add result never does.
        m_ext = {1'b0, m_reg};
        a_sh  = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        a_nxt = a_reg[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
        q_nxt = {q_reg[WIDTH-2:0], ~a_nxt[WIDTH]};

        a_fix = a_reg[WIDTH] ? (a_reg[WIDTH-1:0] + m_reg) : a_reg[WIDTH-1:0];
        q_res = neg_q ? -q_reg : q_reg;
        r_res = neg_r ? -a_fix : a_fix;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg_q <= dvd_neg ^ dvs_neg;
                        neg_r <= dvd_neg;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (signed_mode && dividend == MIN_VAL && divisor == '1) begin
                            quotient    <= MIN_VAL;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            a_reg <= '0;
                            q_reg <= dvd_mag;
                            m_reg <= dvs_mag;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    a_reg       <= {1'b0, a_fix};
                    quotient    <= q_res;
                    remainder   <= r_res;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
